// File: rtl/elevator_ctrl_if.sv
// Panel-side bundle for elevator_ctrl: tick and button inputs, car status outputs.
interface elevator_ctrl_if #(
  parameter int FLOORS = 8,
  parameter int FW     = $clog2(FLOORS)
);
  logic              tick_in;
  logic [FLOORS-1:0] car_req;
  logic [FLOORS-1:0] hall_up;
  logic [FLOORS-1:0] hall_dn;
  logic [FW-1:0]     floor;
  logic              dir_up;
  logic              moving;
  logic              door_open;
  logic [FLOORS-1:0] pending;

  modport master (
    output tick_in, car_req, hall_up, hall_dn,
    input  floor, dir_up, moving, door_open, pending
  );

  modport slave (
    input  tick_in, car_req, hall_up, hall_dn,
    output floor, dir_up, moving, door_open, pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Collective-selective elevator controller (IDLE/MOVE/DOOR) stepping one floor per tick.
// Optional fire recall to floor 0 is built when FIRE_RECALL_EN is defined.
module elevator_ctrl #(
  parameter int FLOORS     = 8,
  parameter int DOOR_TICKS = 3
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef FIRE_RECALL_EN
  input  logic           fire,
`endif
  elevator_ctrl_if.slave bus
);
  localparam int FW = $clog2(FLOORS);
  localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FW-1:0]     TOP   = FW'(FLOORS-1);
  localparam logic [3:0]        CNT_LAST = 4'(DOOR_TICKS-1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t            state, state_nx;
  logic              tick_r, tick_p;
  logic [FW-1:0]     floor_r, floor_nx, step, tgt;
  logic              dir_r, dir_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [FLOORS-1:0] p_car, p_up, p_dn, p_car_nx, p_up_nx, p_dn_nx;
  logic [FLOORS-1:0] req, car_set, up_set, dn_set, clr_car, clr_up, clr_dn;
  logic              ahead, behind, here_dir, here_any, restart, enter;
  logic              moving_r, door_r, moving_nx, door_nx;
`ifdef FIRE_RECALL_EN
  logic              fire_q;
`endif

  function automatic logic beyond(input logic [FLOORS-1:0] v,
                                  input logic [FW-1:0] f, input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (up ? (i > int'(f)) : (i < int'(f))) r = r | v[i];
    return r;
  endfunction

  assign tick_p = bus.tick_in & ~tick_r;
  assign req    = p_car | p_up | p_dn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      moving_r <= 1'b0;
      door_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      moving_r <= moving_nx;
      door_r   <= door_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r  <= 1'b0;
      floor_r <= '0;
      dir_r   <= 1'b1;
      cnt     <= '0;
      p_car   <= '0;
      p_up    <= '0;
      p_dn    <= '0;
    end else begin
      tick_r  <= bus.tick_in;
      floor_r <= floor_nx;
      dir_r   <= dir_nx;
      cnt     <= cnt_nx;
      p_car   <= p_car_nx;
      p_up    <= p_up_nx;
      p_dn    <= p_dn_nx;
    end
  end

`ifdef FIRE_RECALL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_q <= 1'b0;
    else        fire_q <= fire;
  end
`endif

  always_comb begin
    state_nx = state;
    floor_nx = floor_r;
    dir_nx   = dir_r;
    cnt_nx   = cnt;
    enter    = 1'b0;
    tgt      = floor_r;
    ahead    = beyond(req, floor_r, dir_r);
    behind   = beyond(req, floor_r, ~dir_r);
    here_dir = dir_r ? p_up[floor_r] : p_dn[floor_r];
    here_any = p_up[floor_r] | p_dn[floor_r];
    step     = dir_r ? ((floor_r == TOP) ? floor_r : floor_r + FW'(1))
                     : ((floor_r == '0)  ? floor_r : floor_r - FW'(1));
    car_set  = bus.car_req;
    up_set   = bus.hall_up & UP_OK;
    dn_set   = bus.hall_dn & DN_OK;
    restart  = (state == S_DOOR) &&
               (car_set[floor_r] | (dir_r ? up_set[floor_r] : dn_set[floor_r]));

    // An opposite-direction hall call at the floor is only served once nothing lies ahead,
    // otherwise the car would reopen forever instead of continuing its sweep.
    case (state)
      S_IDLE: begin
        if (p_car[floor_r] | here_dir | (~ahead & here_any)) enter = 1'b1;
        else if (ahead) state_nx = S_MOVE;
        else if (behind) begin
          dir_nx   = ~dir_r;
          state_nx = S_MOVE;
        end
      end
      S_MOVE: begin
        if (tick_p) begin
          floor_nx = step;
          tgt      = step;
          if (p_car[step] | (dir_r ? p_up[step] : p_dn[step]) | ~beyond(req, step, dir_r))
            enter = 1'b1;
        end
      end
      S_DOOR: begin
        if (restart) cnt_nx = '0;
        else if (tick_p) begin
          if (cnt == CNT_LAST) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    if (enter) begin
      state_nx     = S_DOOR;
      cnt_nx       = '0;
      clr_car[tgt] = 1'b1;
      if (dir_r) clr_up[tgt] = 1'b1;
      else       clr_dn[tgt] = 1'b1;
      if (!beyond(req, tgt, dir_r)) begin
        clr_up[tgt] = 1'b1;
        clr_dn[tgt] = 1'b1;
        if (beyond(req, tgt, ~dir_r)) dir_nx = ~dir_r;
      end
    end

    // Presses at an open door in its travel direction are absorbed, not queued.
    if (state == S_DOOR) begin
      car_set[floor_r] = 1'b0;
      if (dir_r) up_set[floor_r] = 1'b0;
      else       dn_set[floor_r] = 1'b0;
    end

`ifdef FIRE_RECALL_EN
    if (fire) begin
      car_set  = '0;
      up_set   = '0;
      dn_set   = '0;
      clr_car  = '1;
      clr_up   = '1;
      clr_dn   = '1;
      dir_nx   = 1'b0;
      cnt_nx   = '0;
      floor_nx = floor_r;
      if (floor_r == '0) state_nx = S_DOOR;
      else if (state == S_MOVE && tick_p) begin
        floor_nx = floor_r - FW'(1);
        state_nx = (floor_nx == '0) ? S_DOOR : S_MOVE;
      end else begin
        state_nx = S_MOVE;
      end
    end else if (fire_q && state == S_DOOR) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
`endif

    p_car_nx = (p_car | car_set) & ~clr_car;
    p_up_nx  = (p_up  | up_set)  & ~clr_up;
    p_dn_nx  = (p_dn  | dn_set)  & ~clr_dn;
  end

  always_comb begin
    moving_nx = (state_nx == S_MOVE);
    door_nx   = (state_nx == S_DOOR);
  end

  assign bus.floor     = floor_r;
  assign bus.dir_up    = dir_r;
  assign bus.moving    = moving_r;
  assign bus.door_open = door_r;
  assign bus.pending   = req;
endmodule
